// File: rtl/instr_sequencer_pkg.sv
// instr_sequencer_pkg
//   Types and constants shared by the instruction sequencer and the controller
//   that consumes its timestep/data outputs.
//   - WORD_W            : instruction / data word width
//   - opcode_e          : encoding of the opcode field IR[1:0]
//   - DEFAULT_HALT_WORD : word that terminates a program
//   - seq_state_e       : sequencer FSM states
package instr_sequencer_pkg;

   localparam int unsigned WORD_W = 10;

   // Opcode field IR[1:0]; OpHalt is only meaningful as part of the halt word.
   typedef enum logic [1:0] {
      OpCopy = 2'b00,
      OpLoad = 2'b01,
      OpHalt = 2'b10,
      OpAdd  = 2'b11
   } opcode_e;

   localparam logic [WORD_W-1:0] DEFAULT_HALT_WORD = 10'b0000000010;

   typedef enum logic [1:0] {
      StIdle = 2'b00,
      StRun  = 2'b01,
      StDone = 2'b10
   } seq_state_e;

endpackage

// File: rtl/prog_mem.sv
// prog_mem
//   Program store: DEPTH words of WORD_W bits, synchronous write, asynchronous
//   read, no reset (contents survive sequencer reset).
//   Ports:
//     clk   - write clock
//     we    - write strobe (already qualified by the caller)
//     waddr - write address
//     wdata - write data
//     raddr - read address
//     rdata - read data, combinational from raddr
module prog_mem
   import instr_sequencer_pkg::*;
#(
   parameter int unsigned DEPTH = 32,
   parameter int unsigned AW    = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              we,
   input  logic [AW-1:0]     waddr,
   input  logic [WORD_W-1:0] wdata,
   input  logic [AW-1:0]     raddr,
   output logic [WORD_W-1:0] rdata
);

   logic [WORD_W-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/instr_sequencer.sv
// instr_sequencer
//   Steps through a program held in prog_mem. In RUN the timestep counter
//   advances every cycle (or clears on Clr) and each Ext cycle consumes the
//   current word, presenting it on data in the same cycle. A halt word fetched
//   at timestep 0, or consuming the last address, ends the program in DONE.
//   Ports:
//     clk        - rising-edge clock
//     reset      - synchronous active-high reset
//     run        - 1 = sequence, 0 = pause / idle
//     prog_we    - program-store write strobe (honoured in IDLE/DONE only)
//     prog_addr  - program-store write address
//     prog_wdata - program-store write data
//     Ext        - drive current word on data and consume it
//     Clr        - clear the timestep counter
//     timestep   - timestep counter
//     data       - current word while RUN and Ext, else zero
//     pc         - address of the current word
//     busy       - state is RUN
//     done       - state is DONE
module instr_sequencer
   import instr_sequencer_pkg::*;
#(
   parameter int unsigned       DEPTH     = 32,
   parameter logic [WORD_W-1:0] HALT_WORD = DEFAULT_HALT_WORD
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     run,
   input  logic                     prog_we,
   input  logic [$clog2(DEPTH)-1:0] prog_addr,
   input  logic [WORD_W-1:0]        prog_wdata,
   input  logic                     Ext,
   input  logic                     Clr,
   output logic [1:0]               timestep,
   output logic [WORD_W-1:0]        data,
   output logic [$clog2(DEPTH)-1:0] pc,
   output logic                     busy,
   output logic                     done
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

   seq_state_e        state_q, state_d;
   logic [AW-1:0]     pc_q, pc_d;
   logic [1:0]        ts_q, ts_d;
   logic [WORD_W-1:0] cur_word;
   logic              mem_we;

   // Writes while sequencing are dropped so the running program cannot change.
   assign mem_we = prog_we && (state_q != StRun);

   prog_mem #(
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_prog_mem (
      .clk   (clk),
      .we    (mem_we),
      .waddr (prog_addr),
      .wdata (prog_wdata),
      .raddr (pc_q),
      .rdata (cur_word)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= StIdle;
         pc_q    <= '0;
         ts_q    <= '0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         ts_q    <= ts_d;
      end
   end

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      ts_d    = ts_q;
      unique case (state_q)
         StIdle: begin
            if (run) begin
               state_d = StRun;
            end
         end
         StRun: begin
            if (!run) begin
               // Pause: pc and timestep hold, Ext/Clr ignored.
               state_d = StIdle;
            end else begin
               ts_d = Clr ? 2'd0 : ts_q + 2'd1;
               if (Ext) begin
                  if ((ts_q == 2'd0) && (cur_word == HALT_WORD)) begin
                     state_d = StDone;
                     ts_d    = 2'd0;
                  end else if (pc_q == LAST_ADDR) begin
                     // End of store: stop rather than wrap.
                     state_d = StDone;
                     ts_d    = 2'd0;
                  end else begin
                     pc_d = pc_q + AW'(1);
                  end
               end
            end
         end
         StDone: begin
            // Only reset leaves DONE.
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   assign timestep = ts_q;
   assign pc       = pc_q;
   assign busy     = (state_q == StRun);
   assign done     = (state_q == StDone);
   assign data     = ((state_q == StRun) && Ext) ? cur_word : '0;

endmodule

// File: tb/tb_instr_sequencer.sv
module tb_instr_sequencer;
   import instr_sequencer_pkg::*;

   localparam int unsigned DEPTH = 32;
   localparam int unsigned AW    = 5;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          run = 1'b0;
   logic          prog_we = 1'b0;
   logic [AW-1:0] prog_addr = '0;
   logic [9:0]    prog_wdata = '0;
   logic          Ext = 1'b0;
   logic          Clr = 1'b0;
   logic [1:0]    timestep;
   logic [9:0]    data;
   logic [AW-1:0] pc;
   logic          busy;
   logic          done;

   instr_sequencer #(
      .DEPTH     (DEPTH),
      .HALT_WORD (DEFAULT_HALT_WORD)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .run        (run),
      .prog_we    (prog_we),
      .prog_addr  (prog_addr),
      .prog_wdata (prog_wdata),
      .Ext        (Ext),
      .Clr        (Clr),
      .timestep   (timestep),
      .data       (data),
      .pc         (pc),
      .busy       (busy),
      .done       (done)
   );

   always #5 clk = ~clk;

   // Scoreboard: expectations queued when stimulus is driven, popped on compare.
   string       tag_q[$];
   logic [31:0] exp_q[$];
   int          checks = 0;
   int          failures = 0;
   logic [9:0]  mem_m [DEPTH];
   int          pc_m;
   logic [1:0]  ts_m;

   localparam logic [9:0] COPY_WORD = {8'h35, 2'b00};
   localparam logic [9:0] LOAD_WORD = {8'hCC, 2'b01};
   localparam logic [9:0] OPERAND   = 10'h2A5;

   function automatic logic [9:0] word_of(input int i);
      return {8'(i * 37 + 5), 2'b01};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input string tag, input logic [31:0] v);
      tag_q.push_back(tag);
      exp_q.push_back(v);
   endtask

   task automatic compare(input logic [31:0] obs);
      string       t;
      logic [31:0] e;
      checks++;
      if (exp_q.size() == 0) begin
         failures++;
         $error("FAIL scoreboard_empty observed=%0h expected=none", obs);
      end else begin
         t = tag_q.pop_front();
         e = exp_q.pop_front();
         assert (obs === e) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", t, obs, e);
         end
      end
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] e);
      push(tag, e);
      compare(obs);
   endtask

   task automatic prog_write(input int a, input logic [9:0] w);
      prog_we    = 1'b1;
      prog_addr  = AW'(a);
      prog_wdata = w;
      tick();
      prog_we    = 1'b0;
      mem_m[a]   = w;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      run = 1'b0;
      Ext = 1'b0;
      Clr = 1'b0;
      prog_we = 1'b0;
      tick();
      reset = 1'b0;
   endtask

   initial begin
      // Reset state; Ext outside RUN must not drive data.
      tick();
      do_reset();
      Ext = 1'b1;
      #1;
      chk("rst_pc", 32'(pc), 0);
      chk("rst_ts", 32'(timestep), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_done", 32'(done), 0);
      chk("rst_data_ext_idle", 32'(data), 0);
      Ext = 1'b0;

      // COPY then HALT.
      prog_write(0, COPY_WORD);
      prog_write(1, DEFAULT_HALT_WORD);
      run = 1'b1;
      tick();
      chk("a_busy", 32'(busy), 1);
      Ext = 1'b1;
      #1;
      chk("a_data_ts0", 32'(data), 32'(COPY_WORD));
      tick();
      chk("a_pc_after_ext", 32'(pc), 1);
      chk("a_ts_after_ext", 32'(timestep), 1);
      Ext = 1'b0;
      Clr = 1'b1;
      push("a_pc_after_clr", 1);
      push("a_ts_after_clr", 0);
      tick();
      compare(32'(pc));
      compare(32'(timestep));
      Clr = 1'b0;
      Ext = 1'b1;
      #1;
      chk("a_data_halt", 32'(data), 32'(DEFAULT_HALT_WORD));
      tick();
      chk("a_done", 32'(done), 1);
      chk("a_done_pc", 32'(pc), 1);
      chk("a_done_ts", 32'(timestep), 0);
      chk("a_done_busy", 32'(busy), 0);
      chk("a_done_data", 32'(data), 0);

      // LOAD with operand at ts1, Ext+Clr together.
      do_reset();
      prog_write(0, LOAD_WORD);
      prog_write(1, OPERAND);
      run = 1'b1;
      tick();
      Ext = 1'b1;
      #1;
      chk("b_data_ts0", 32'(data), 32'(LOAD_WORD));
      tick();
      chk("b_pc1", 32'(pc), 1);
      Clr = 1'b1;
      #1;
      chk("b_operand_ts1", 32'(data), 32'(OPERAND));
      push("b_pc2", 2);
      push("b_ts_clr", 0);
      tick();
      compare(32'(pc));
      compare(32'(timestep));

      // Free-running timestep wrap.
      Ext = 1'b0;
      Clr = 1'b0;
      ts_m = 2'd0;
      chk("c_ts_start", 32'(timestep), 32'(ts_m));
      for (int k = 0; k < 5; k++) begin
         ts_m = ts_m + 2'd1;
         push($sformatf("c_ts_%0d", k + 1), 32'(ts_m));
         tick();
         compare(32'(timestep));
      end

      // Pause mid-program, dropped write, resume, run to end of store.
      do_reset();
      for (int i = 0; i < DEPTH; i++) prog_write(i, word_of(i));
      run = 1'b1;
      tick();
      Ext = 1'b1;
      Clr = 1'b1;
      tick();
      Clr = 1'b0;
      tick();
      tick();
      chk("d_pc3", 32'(pc), 3);
      chk("d_ts2", 32'(timestep), 2);
      run = 1'b0;
      Ext = 1'b0;
      prog_we = 1'b1;
      prog_addr = AW'(7);
      prog_wdata = 10'h155;
      tick();
      prog_we = 1'b0;
      chk("d_pause_busy", 32'(busy), 0);
      Ext = 1'b1;
      Clr = 1'b1;
      tick();
      chk("d_pause_pc", 32'(pc), 3);
      chk("d_pause_ts", 32'(timestep), 2);
      chk("d_pause_data", 32'(data), 0);
      Ext = 1'b0;
      Clr = 1'b0;
      run = 1'b1;
      tick();
      chk("d_resume_busy", 32'(busy), 1);
      chk("d_resume_pc", 32'(pc), 3);
      chk("d_resume_ts", 32'(timestep), 2);
      Ext = 1'b1;
      pc_m = 3;
      for (int k = 0; k < 28; k++) begin
         #1;
         chk($sformatf("d_data_pc%0d", pc_m), 32'(data), 32'(mem_m[pc_m]));
         tick();
         pc_m++;
      end
      chk("d_pc_last", 32'(pc), 31);
      chk("d_busy_last", 32'(busy), 1);
      push("d_done", 1);
      push("d_done_pc", 31);
      push("d_done_ts", 0);
      tick();
      compare(32'(done));
      compare(32'(pc));
      compare(32'(timestep));
      chk("d_done_data", 32'(data), 0);
      run = 1'b0;
      Clr = 1'b1;
      tick();
      chk("d_done_sticky", 32'(done), 1);
      chk("d_done_sticky_pc", 32'(pc), 31);
      Clr = 1'b0;
      Ext = 1'b0;
      prog_write(2, 10'h0F1);

      // Reset mid-RUN at pc=5, memory retained.
      do_reset();
      run = 1'b1;
      tick();
      Ext = 1'b1;
      pc_m = 0;
      for (int k = 0; k < 5; k++) begin
         #1;
         chk($sformatf("e_data_pc%0d", pc_m), 32'(data), 32'(mem_m[pc_m]));
         tick();
         pc_m++;
      end
      chk("e_pc5", 32'(pc), 5);
      reset = 1'b1;
      Clr = 1'b1;
      prog_we = 1'b1;
      prog_addr = AW'(0);
      prog_wdata = 10'h3FD;
      push("e_rst_pc", 0);
      push("e_rst_ts", 0);
      push("e_rst_busy", 0);
      push("e_rst_done", 0);
      tick();
      compare(32'(pc));
      compare(32'(timestep));
      compare(32'(busy));
      compare(32'(done));
      reset = 1'b0;
      prog_we = 1'b0;
      Clr = 1'b0;
      Ext = 1'b0;
      tick();
      Ext = 1'b1;
      #1;
      chk("e_mem0_kept", 32'(data), 32'(mem_m[0]));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
